mc_datapath: RTL and testbench

//  Multicycle successor to the single-cycle MIPS datapath. Same RTL building blocks: ALU, registers, SignExtend, Adder, Mux21.

---
 rtl/mc_datapath_if.sv | 43 ++++
 rtl/mc_datapath.sv | 244 ++++++++++++++++++++++++
 tb/tb_mc_datapath.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_if.sv
// ---------------------------------------------------------------------------
// mc_datapath_if
// Memory-side handshake bundle for the multicycle MIPS datapath.
//   imem_req   datapath -> memory   instruction fetch request (address = PC)
//   imem_ack   memory -> datapath   fetch complete, imem_rdata valid this cycle
//   imem_rdata memory -> datapath   fetched 32-bit instruction word
//   dmem_req   datapath -> memory   data request (address = ALUOut)
//   dmem_we    datapath -> memory   1 = store (data = WriteData), 0 = load
//   dmem_ack   memory -> datapath   data complete, dmem_rdata valid on loads
//   dmem_rdata memory -> datapath   load data, WIDTH bits
// Modports: master = datapath side, slave = memory side.
// ---------------------------------------------------------------------------
interface mc_datapath_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             dmem_req;
    logic             dmem_we;
    logic             dmem_ack;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        output imem_req,
        input  imem_ack,
        input  imem_rdata,
        output dmem_req,
        output dmem_we,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  imem_req,
        output imem_ack,
        output imem_rdata,
        input  dmem_req,
        input  dmem_we,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/mc_datapath.sv
// ---------------------------------------------------------------------------
// mc_datapath
// Multicycle MIPS datapath. Each instruction walks FETCH -> DECODE -> EXEC
// -> (MEM) -> (WB); instruction and data memories are reached through
// req/ack handshakes so any memory latency is tolerated. Control signals
// come from an external combinational decoder watching Instruction.
//
// Parameters
//   WIDTH     datapath / register / PC width (32 or 64)
//   PC_RESET  PC value after reset
//   RF_DEPTH  register count; r0 always reads 0, writes to r0 are dropped
//
// Ports
//   clk, reset                clock, asynchronous active-low reset
//   RegDst..Jump, ALUCtrl     control from the external decoder
//   Instruction               instruction register (IR)
//   memBus                    imem/dmem handshake bundle (master side)
//   PC                        program counter (fetch address)
//   ALUOut                    registered ALU result (data address)
//   WriteData                 B register (store data)
//   retire                    one-cycle pulse per completed instruction
//
// Optional feature: define MC_DP_JAL_EN to make opcode 6'b000011 (JAL) take
// the jump path and write PC+4 into r31 during EXEC.
// ---------------------------------------------------------------------------
module mc_datapath #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_RESET = '0,
    parameter int               RF_DEPTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegDst,
    input  logic               RegWrite,
    input  logic               MemtoReg,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic               ALUSrc,
    input  logic               Branch,
    input  logic               Jump,
    input  logic [3:0]         ALUCtrl,
    output logic [31:0]        Instruction,
    mc_datapath_if.master      memBus,
    output logic [WIDTH-1:0]   PC,
    output logic [WIDTH-1:0]   ALUOut,
    output logic [WIDTH-1:0]   WriteData,
    output logic               retire
);

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    logic [2:0]       state;
    logic [31:0]      irReg;
    logic [WIDTH-1:0] pcReg;
    logic [WIDTH-1:0] aReg;
    logic [WIDTH-1:0] bReg;
    logic [WIDTH-1:0] aluOutReg;
    logic [WIDTH-1:0] mdrReg;
    logic             imemReqReg;
    logic             dmemReqReg;
    logic             retireReg;

    logic [WIDTH-1:0] rf [RF_DEPTH];

    // Instruction fields
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] immExt;

    assign rs     = irReg[25:21];
    assign rt     = irReg[20:16];
    assign rd     = irReg[15:11];
    assign shamt  = irReg[10:6];
    assign immExt = {{(WIDTH-16){irReg[15]}}, irReg[15:0]};

    logic isJal;
`ifdef MC_DP_JAL_EN
    assign isJal = (irReg[31:26] == 6'b000011);
`else
    assign isJal = 1'b0;
`endif

    // ALU
    logic [WIDTH-1:0] aluB;
    logic [WIDTH-1:0] aluResult;
    logic             aluZero;

    assign aluB = ALUSrc ? immExt : bReg;

    always_comb begin
        aluResult = '0;
        case (ALUCtrl)
            4'b0000: aluResult = aReg & aluB;
            4'b0001: aluResult = aReg | aluB;
            4'b0010: aluResult = aReg + aluB;
            4'b0011: aluResult = aluB << shamt;
            4'b0100: aluResult = aluB >> shamt;
            4'b0101: aluResult = $signed(aluB) >>> shamt;
            4'b0110: aluResult = aReg - aluB;
            4'b0111: aluResult = {{(WIDTH-1){1'b0}}, ($signed(aReg) < $signed(aluB))};
            4'b1000: aluResult = aReg ^ aluB;
            4'b1100: aluResult = ~(aReg | aluB);
            default: aluResult = '0;
        endcase
    end

    assign aluZero = (aluResult == '0);

    // Next-PC selection: jump beats branch beats sequential.
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] branchTarget;
    logic [WIDTH-1:0] jumpTarget;
    logic [WIDTH-1:0] nextPc;

    assign pc4          = pcReg + WIDTH'(4);
    assign branchTarget = pc4 + (immExt << 2);
    assign jumpTarget   = {pc4[WIDTH-1:28], irReg[25:0], 2'b00};

    always_comb begin
        nextPc = pc4;
        if (Jump || isJal)
            nextPc = jumpTarget;
        else if (Branch && aluZero)
            nextPc = branchTarget;
    end

    // Register-file write port: normal writeback in WB, link write in EXEC.
    logic             wrEn;
    logic [4:0]       wrAddr;
    logic [WIDTH-1:0] wrData;

    always_comb begin
        wrEn   = 1'b0;
        wrAddr = rt;
        wrData = aluOutReg;
        if (state == WB && RegWrite) begin
            wrEn   = 1'b1;
            wrAddr = RegDst ? rd : rt;
            wrData = MemtoReg ? mdrReg : aluOutReg;
        end
`ifdef MC_DP_JAL_EN
        if (state == EXEC && isJal) begin
            wrEn   = 1'b1;
            wrAddr = 5'd31;
            wrData = pc4;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wrEn && wrAddr != 5'd0)
            rf[wrAddr] <= wrData;
    end

    // Phase sequencer. Request flags are registered so they drop to 0 the
    // instant reset asserts and rise one cycle after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            pcReg      <= PC_RESET;
            irReg      <= '0;
            aReg       <= '0;
            bReg       <= '0;
            aluOutReg  <= '0;
            mdrReg     <= '0;
            imemReqReg <= 1'b0;
            dmemReqReg <= 1'b0;
            retireReg  <= 1'b0;
        end else begin
            retireReg <= 1'b0;
            case (state)
                FETCH: begin
                    // An ack is only honoured while our request is up.
                    if (imemReqReg && memBus.imem_ack) begin
                        irReg      <= memBus.imem_rdata;
                        imemReqReg <= 1'b0;
                        state      <= DECODE;
                    end else begin
                        imemReqReg <= 1'b1;
                    end
                end
                DECODE: begin
                    aReg  <= (rs == 5'd0) ? '0 : rf[rs];
                    bReg  <= (rt == 5'd0) ? '0 : rf[rt];
                    state <= EXEC;
                end
                EXEC: begin
                    aluOutReg <= aluResult;
                    pcReg     <= nextPc;
                    if (!isJal && (MemRead || MemWrite)) begin
                        dmemReqReg <= 1'b1;
                        state      <= MEM;
                    end else if (!isJal && RegWrite) begin
                        state <= WB;
                    end else begin
                        imemReqReg <= 1'b1;
                        retireReg  <= 1'b1;
                        state      <= FETCH;
                    end
                end
                MEM: begin
                    if (dmemReqReg && memBus.dmem_ack) begin
                        dmemReqReg <= 1'b0;
                        // MemRead wins when both are set.
                        if (MemRead) begin
                            mdrReg <= memBus.dmem_rdata;
                            state  <= WB;
                        end else begin
                            imemReqReg <= 1'b1;
                            retireReg  <= 1'b1;
                            state      <= FETCH;
                        end
                    end
                end
                WB: begin
                    imemReqReg <= 1'b1;
                    retireReg  <= 1'b1;
                    state      <= FETCH;
                end
                default: begin
                    imemReqReg <= 1'b0;
                    dmemReqReg <= 1'b0;
                    state      <= FETCH;
                end
            endcase
        end
    end

    assign Instruction     = irReg;
    assign PC              = pcReg;
    assign ALUOut          = aluOutReg;
    assign WriteData       = bReg;
    assign retire          = retireReg;
    assign memBus.imem_req = imemReqReg;
    assign memBus.dmem_req = dmemReqReg;
    assign memBus.dmem_we  = dmemReqReg & MemWrite & ~MemRead;

endmodule

// File: tb/tb_mc_datapath.sv
// ---------------------------------------------------------------------------
// tb_mc_datapath
// Directed bench for mc_datapath: a small MIPS program is placed in a bench
// instruction memory, a combinational controller decodes Instruction, and
// bench memories answer the req/ack handshakes with programmable waits.
// Expected retire PCs/latencies and memory transactions are queued as the
// program is loaded and popped when the DUT retires or hits data memory.
// ---------------------------------------------------------------------------
module tb_mc_datapath;
    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegDst, RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, Branch, Jump;
    logic [3:0]  ALUCtrl;
    logic [31:0] Instruction;
    logic [31:0] PC, ALUOut, WriteData;
    logic        retire;

    mc_datapath_if #(.WIDTH(WIDTH)) memBus ();

    mc_datapath #(.WIDTH(WIDTH), .PC_RESET(32'h0), .RF_DEPTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .MemtoReg    (MemtoReg),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .ALUSrc      (ALUSrc),
        .Branch      (Branch),
        .Jump        (Jump),
        .ALUCtrl     (ALUCtrl),
        .Instruction (Instruction),
        .memBus      (memBus),
        .PC          (PC),
        .ALUOut      (ALUOut),
        .WriteData   (WriteData),
        .retire      (retire)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Controller: combinational decode of the instruction register.
    always_comb begin
        RegDst = 1'b0; RegWrite = 1'b0; MemtoReg = 1'b0; MemRead = 1'b0;
        MemWrite = 1'b0; ALUSrc = 1'b0; Branch = 1'b0; Jump = 1'b0;
        ALUCtrl = 4'b0010;
        case (Instruction[31:26])
            6'h00: begin
                RegDst = 1'b1; RegWrite = 1'b1;
                ALUCtrl = (Instruction[5:0] == 6'h22) ? 4'b0110 : 4'b0010;
            end
            6'h08: begin RegWrite = 1'b1; ALUSrc = 1'b1; end
            6'h23: begin RegWrite = 1'b1; ALUSrc = 1'b1; MemtoReg = 1'b1; MemRead = 1'b1; end
            6'h2B: begin ALUSrc = 1'b1; MemWrite = 1'b1; end
            6'h04: begin Branch = 1'b1; ALUCtrl = 4'b0110; end
            6'h02: Jump = 1'b1;
            6'h03: Jump = 1'b1;
            default: ;
        endcase
    end

    function automatic logic [31:0] rT(input int rs, input int rt, input int rd, input logic [5:0] funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, funct};
    endfunction
    function automatic logic [31:0] iT(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] jT(input logic [5:0] op, input logic [25:0] target);
        return {op, target};
    endfunction

    // Scoreboard
    typedef struct { logic [31:0] pc; int lat; } retire_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } memop_t;
    retire_t retQ[$];
    memop_t  memQ[$];

    logic [31:0] imemArr [logic [31:0]];
    logic [31:0] dmemArr [logic [31:0]];

    int fetchWait = 0;
    int dmemWait  = 3;
    int cycle     = 0;
    int lastRetire = 0;
    bit sbOn      = 1'b0;

    task automatic addInstr(input logic [31:0] addr, input logic [31:0] word,
                            input logic [31:0] nextPc, input int lat);
        retire_t e;
        imemArr[addr] = word;
        e.pc = nextPc;
        e.lat = lat;
        retQ.push_back(e);
    endtask

    task automatic addMem(input logic we, input logic [31:0] addr, input logic [31:0] data);
        memop_t m;
        m.we = we; m.addr = addr; m.data = data;
        memQ.push_back(m);
    endtask

    // Instruction memory responder
    initial begin
        int fCnt;
        fCnt = 0;
        memBus.imem_ack = 1'b0;
        memBus.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (memBus.imem_req && !memBus.imem_ack) begin
                if (fCnt >= fetchWait) begin
                    memBus.imem_ack = 1'b1;
                    memBus.imem_rdata = imemArr.exists(PC) ? imemArr[PC] : 32'h0;
                    fCnt = 0;
                end else begin
                    fCnt++;
                end
            end else begin
                memBus.imem_ack = 1'b0;
                fCnt = 0;
            end
        end
    end

    // Data memory responder and memory-op scoreboard
    initial begin
        int dCnt;
        memop_t m;
        dCnt = 0;
        memBus.dmem_ack = 1'b0;
        memBus.dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (memBus.dmem_req && !memBus.dmem_ack) begin
                if (dCnt >= dmemWait) begin
                    check("dmem req cycles", 32'(dCnt + 1), 32'(dmemWait + 1));
                    checks++;
                    assert (memQ.size() != 0) else begin
                        errors++;
                        $error("FAIL dmem unexpected: observed addr 0x%08h expected no access", ALUOut);
                    end
                    if (memQ.size() != 0) begin
                        m = memQ.pop_front();
                        check("dmem we", {31'h0, memBus.dmem_we}, {31'h0, m.we});
                        check("dmem addr", ALUOut, m.addr);
                        if (m.we) check("store data", WriteData, m.data);
                    end
                    if (memBus.dmem_we) dmemArr[ALUOut] = WriteData;
                    memBus.dmem_rdata = dmemArr.exists(ALUOut) ? dmemArr[ALUOut] : 32'h0;
                    memBus.dmem_ack = 1'b1;
                    dCnt = 0;
                end else begin
                    dCnt++;
                end
            end else begin
                memBus.dmem_ack = 1'b0;
                dCnt = 0;
            end
        end
    end

    // Retire monitor
    initial begin
        retire_t e;
        forever begin
            @(posedge clk);
            cycle++;
            #1;
            if (reset && retire) begin
                if (sbOn) begin
                    checks++;
                    assert (retQ.size() != 0) else begin
                        errors++;
                        $error("FAIL retire unexpected: observed PC 0x%08h expected no retire", PC);
                    end
                    if (retQ.size() != 0) begin
                        e = retQ.pop_front();
                        $display("retire: PC=0x%08h latency=%0d (expected 0x%08h, %0d)", PC, cycle - lastRetire, e.pc, e.lat);
                        check("retire pc", PC, e.pc);
                        check("retire latency", 32'(cycle - lastRetire), 32'(e.lat));
                    end
                end
                lastRetire = cycle;
            end
        end
    end

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (retQ.size() != 0 && n < 600) begin
            @(posedge clk);
            n++;
        end
        sbOn = 1'b0;
        check({tag, " retire queue drained"}, 32'(retQ.size()), 32'h0);
        check({tag, " mem queue drained"}, 32'(memQ.size()), 32'h0);
    endtask

    logic [31:0] r31Exp;

    initial begin
        int n;
        reset = 1'b0;
`ifdef MC_DP_JAL_EN
        r31Exp = 32'h0000_0408;
`else
        r31Exp = 32'h0000_0077;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset PC", PC, 32'h0);
        check("reset imem_req", {31'h0, memBus.imem_req}, 32'h0);
        check("reset dmem_req", {31'h0, memBus.dmem_req}, 32'h0);
        check("reset retire", {31'h0, retire}, 32'h0);
        check("reset Instruction", Instruction, 32'h0);
        check("reset ALUOut", ALUOut, 32'h0);
        check("reset WriteData", WriteData, 32'h0);

        // Phase 1 program
        addInstr(32'h000, iT(6'h08, 0, 1, 16'd5),      32'h004, 4);
        addInstr(32'h004, rT(1, 1, 2, 6'h20),          32'h008, 4);
        addInstr(32'h008, iT(6'h2B, 0, 2, 16'd8),      32'h00C, 7);
        addMem(1'b1, 32'h8, 32'd10);
        addInstr(32'h00C, iT(6'h23, 0, 3, 16'd8),      32'h010, 8);
        addMem(1'b0, 32'h8, 32'h0);
        addInstr(32'h010, iT(6'h2B, 0, 3, 16'd12),     32'h014, 7);
        addMem(1'b1, 32'hC, 32'd10);
        addInstr(32'h014, iT(6'h08, 0, 0, 16'd7),      32'h018, 4);
        addInstr(32'h018, jT(6'h02, 26'h8),            32'h020, 3);
        addInstr(32'h020, iT(6'h04, 1, 1, 16'hFFFE),   32'h01C, 3);
        addInstr(32'h01C, jT(6'h02, 26'h9),            32'h024, 3);
        addInstr(32'h024, iT(6'h04, 1, 2, 16'd5),      32'h028, 3);
        addInstr(32'h028, iT(6'h08, 0, 31, 16'h77),    32'h02C, 4);
        addInstr(32'h02C, jT(6'h02, 26'h100),          32'h400, 3);
        addInstr(32'h400, iT(6'h2B, 0, 0, 16'd16),     32'h404, 7);
        addMem(1'b1, 32'h10, 32'h0);
        addInstr(32'h404, jT(6'h03, 26'h40),           32'h100, 3);
        addInstr(32'h100, iT(6'h2B, 0, 31, 16'd20),    32'h104, 7);
        addMem(1'b1, 32'h14, r31Exp);
        addInstr(32'h104, iT(6'h04, 0, 0, 16'hFFFF),   32'h104, 3);

        fetchWait = 0;
        dmemWait = 3;
        sbOn = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        lastRetire = cycle + 1;
        drain("phase1");

        // Reset while a fetch is stalled
        fetchWait = 1000;
        n = 0;
        while (!memBus.imem_req && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stalled fetch req", {31'h0, memBus.imem_req}, 32'h1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check("async reset PC", PC, 32'h0);
        check("async reset imem_req", {31'h0, memBus.imem_req}, 32'h0);
        check("async reset retire", {31'h0, retire}, 32'h0);
        check("async reset Instruction", Instruction, 32'h0);
        @(posedge clk);
        #1;
        check("reset hold imem_req", {31'h0, memBus.imem_req}, 32'h0);

        // Phase 2: branch below zero, then sequential wrap back to zero
        imemArr.delete();
        addInstr(32'h0000_0000, iT(6'h04, 0, 0, 16'hFFFE), 32'hFFFF_FFFC, 3);
        addInstr(32'hFFFF_FFFC, iT(6'h08, 0, 5, 16'd1),    32'h0000_0000, 4);
        fetchWait = 0;
        sbOn = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        lastRetire = cycle + 1;
        #1;
        check("release imem_req same cycle", {31'h0, memBus.imem_req}, 32'h0);
        @(posedge clk);
        #1;
        check("release imem_req next cycle", {31'h0, memBus.imem_req}, 32'h1);
        drain("phase2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
